// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Purpose: shares one single-port, variable-latency memory between the
// fetch stage (instruction reads) and the memory stage (data loads and
// stores) of the pipelined MIPS core. Each transaction is a req/ack
// handshake with the memory. Read data is returned in registers, and the
// stall signals for the hazard unit are generated here.
//
// Ports:
//   clk, reset           rising-edge clock; asynchronous active-low reset
//   if_req/if_addr       fetch read request, held until if_valid
//   if_rdata/if_valid    registered instruction data, one-cycle retire pulse
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store), held until d_valid
//   d_rdata/d_valid      registered load data, one-cycle retire pulse
//   stall_f/stall_m      combinational stalls: req & ~valid
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack    memory read data, sampled with one-cycle ack
//   err                  one-cycle pulse when the watchdog aborts an access
//
// Parameters:
//   MAX_STREAK  consecutive data grants allowed while a fetch is waiting
//   TIMEOUT     ACCESS cycles without ack before abort (0 = no watchdog)

module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        stall_f,
  output logic        stall_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          err_q, err_d;

  logic          fetch_grant;
  logic          data_grant;
  logic          tmo_expire;

  // Data wins by default; a waiting fetch takes the port once data has
  // used up its streak allowance.
  assign fetch_grant = if_req && (!d_req || (streak_q == STREAK_MAX));
  assign data_grant  = d_req && !fetch_grant;

  // Fires on the TIMEOUT-th ACCESS cycle without an ack.
  assign tmo_expire = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  // Next-state and datapath updates; valid/err default low so they pulse
  // for exactly the one RESP cycle that follows retirement.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_grant) begin
          owner_d     = OWN_FETCH;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          streak_d    = '0;
          state_d     = ACCESS;
        end else if (data_grant) begin
          owner_d     = OWN_DATA;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          // Only count data grants that actually made a fetch wait.
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        // An ack arriving together with the timeout completes normally.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_valid_d = 1'b1;
          end
          state_d = RESP;
        end else if (tmo_expire) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = '0;
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign err       = err_q;

  // Stalls release in the RESP cycle so the pipeline advances with valid.
  assign stall_f = if_req & ~if_valid_q;
  assign stall_m = d_req & ~d_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipelined MIPS core.
- Arbitrates between the two requesters and sequences each memory transaction with a req/ack handshake.
- Returns read data and generates the stall signals consumed by the hazard unit.
- Sits between the pipeline stages and the external memory model.

Parameters:
- MAX_STREAK, 4: maximum consecutive data grants while a fetch is pending; the next grant then goes to fetch.
- TIMEOUT, 255: cycles without mem_ack before a transaction is aborted. 0 disables the watchdog.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch read request, held until if_valid.
- if_addr  input  32  fetch address (pcF).
- if_rdata  output  32  instruction read data, registered.
- if_valid  output  1  one-cycle pulse: if_rdata valid, fetch request retired.
- d_req  input  1  data request, held until d_valid.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data address (aluoutM).
- d_wdata  input  32  store data (writedataM).
- d_rdata  output  32  load data, registered.
- d_valid  output  1  one-cycle pulse: data transaction retired.
- stall_f  output  1  fetch stall = if_req & ~if_valid (combinational).
- stall_m  output  1  memory-stage stall = d_req & ~d_valid (combinational).
- mem_req  output  1  memory request, registered.
- mem_we  output  1  memory write enable, registered.
- mem_addr  output  32  memory address, registered.
- mem_wdata  output  32  memory write data, registered.
- mem_rdata  input  32  memory read data, sampled with mem_ack.
- mem_ack  input  1  memory completion, one cycle.
- err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; streak counter and timeout counter clear.
  - All registered outputs clear to 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_valid, d_valid, err.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Grant rule: data has priority. Exception: if_req=1 and streak == MAX_STREAK, then fetch wins.
  - On a grant: latch owner, mem_addr, mem_we (0 for fetch), mem_wdata; set mem_req=1; go to ACCESS.
- Streak counter:
  - Increments on a data grant while if_req=1, saturating at MAX_STREAK.
  - Clears on a fetch grant, and on a data grant while if_req=0.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack.
  - On mem_ack: mem_req goes to 0; mem_rdata is captured into the owner's rdata (loads and fetches only; the store rdata register is unchanged); go to RESP.
  - Timeout counter increments each ACCESS cycle without mem_ack. On reaching TIMEOUT: mem_req goes to 0, err pulses, owner's valid pulses with rdata = 0, go to RESP.
  - Timeout counter clears on grant.
- RESP:
  - The owner's valid is high for exactly this one cycle, then return to IDLE.
  - Arbitration resumes in the following IDLE cycle, so there is one bubble between transactions.
- Latency:
  - Request first seen in IDLE at cycle 0; mem_req high from cycle 1.
  - mem_ack at cycle k (k ≥ 1) gives valid at cycle k+1.
  - Minimum request-to-valid latency: 2 cycles.
- Requester contract: req and its address/data are held until valid. If a req drops mid-transaction, the transaction still completes and valid still pulses; the requester ignores it.
- Simultaneous events:
  - if_req and d_req together in IDLE: the grant rule decides.
  - mem_ack in the same cycle the timeout is reached: ack wins; no err.
  - mem_ack while in IDLE or RESP: ignored.
- Reset mid-transaction: abort immediately, with no valid and no err. The memory side treats a dropped mem_req as cancellation.
- Stall outputs: stall_f and stall_m are combinational only. Both are 0 whenever the respective valid is high, so the pipeline advances in the RESP cycle.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x00400000; mem_ack 1 cycle after mem_req with mem_rdata=0x20080005 -> mem_req high cycle 1, if_valid cycle 2, if_rdata=0x20080005, stall_f high cycles 0–1.
- Contention: if_req and d_req (load, d_addr=0x10010000) both asserted at cycle 0 with streak 0 -> data is served first (d_valid, d_rdata=mem_rdata); fetch is granted in the next IDLE; mem_we stays 0 for both.
- Starvation guard (MAX_STREAK=4): d_req held high continuously and if_req held high -> exactly 4 data grants, then 1 fetch grant, then data again; streak reads 0 after the fetch grant.
- Store: d_we=1, d_addr=0x1001000C, d_wdata=0xDEADBEEF, mem_ack after 3 cycles -> mem_we=1 and mem_wdata=0xDEADBEEF stable throughout ACCESS; d_valid pulses once; d_rdata unchanged.
- Watchdog (TIMEOUT=8): fetch issued, mem_ack never asserted -> after 8 ACCESS cycles mem_req drops, err and if_valid pulse together, if_rdata=0. A second run with mem_ack on the 8th cycle -> no err.
- Async reset: assert reset=0 mid-ACCESS between clock edges -> mem_req, valid and err go to 0 immediately; after release, state is IDLE with no spurious valid.
